// File: rtl/oc_dispatch_arbiter_if.sv
// Handshake bundle between the operand-collector entries and the dispatch arbiter.
// master = OC / issue side, slave = arbiter.
interface oc_dispatch_arbiter_if #(
  parameter int unsigned NUM_OC = 4
);
  logic [NUM_OC-1:0] Ready_OC;
  logic [NUM_OC-1:0] Is_Mem_OC;
  logic              ALU_Ready;
  logic              MEM_Ready;
  logic [NUM_OC-1:0] ALU_Grt;
  logic [NUM_OC-1:0] MEM_Grt;
  logic [NUM_OC-1:0] Release_OC;
  logic [NUM_OC-1:0] Pending_OC;

  modport master (
    output Ready_OC, Is_Mem_OC, ALU_Ready, MEM_Ready,
    input  ALU_Grt, MEM_Grt, Release_OC, Pending_OC
  );

  modport slave (
    input  Ready_OC, Is_Mem_OC, ALU_Ready, MEM_Ready,
    output ALU_Grt, MEM_Grt, Release_OC, Pending_OC
  );
endinterface

// File: rtl/oc_dispatch_arbiter.sv
// Issue-side arbiter for the 4-entry operand collector: independent round-robin
// grants to ALU and MEM, with a one-cycle release pulse back to each granted OC.
module oc_dispatch_arbiter #(
  parameter int unsigned NUM_OC = 4,
  parameter int unsigned PTR_W  = 2
) (
  input logic                  clk,
  input logic                  rst,
  oc_dispatch_arbiter_if.slave bus
);

  logic [PTR_W-1:0]  alu_ptr;
  logic [PTR_W-1:0]  mem_ptr;
  logic [NUM_OC-1:0] pending;

  logic [NUM_OC-1:0] elig;
  logic [NUM_OC-1:0] alu_req;
  logic [NUM_OC-1:0] mem_req;
  logic [PTR_W:0]    alu_pick;
  logic [PTR_W:0]    mem_pick;
  logic [NUM_OC-1:0] alu_grt;
  logic [NUM_OC-1:0] mem_grt;

  // Returns {found, index} of the first set request scanning upward from ptr.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_OC-1:0] req,
                                             input logic [PTR_W-1:0]  ptr);
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_OC; k++) begin
      idx = ptr + PTR_W'(k);
      if (!res[PTR_W] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    elig     = bus.Ready_OC & ~pending;
    alu_req  = elig & ~bus.Is_Mem_OC & {NUM_OC{bus.ALU_Ready}};
    mem_req  = elig &  bus.Is_Mem_OC & {NUM_OC{bus.MEM_Ready}};
    alu_pick = rr_pick(alu_req, alu_ptr);
    mem_pick = rr_pick(mem_req, mem_ptr);
    alu_grt  = '0;
    mem_grt  = '0;
    if (!rst && alu_pick[PTR_W]) alu_grt[alu_pick[PTR_W-1:0]] = 1'b1;
    if (!rst && mem_pick[PTR_W]) mem_grt[mem_pick[PTR_W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ptr <= '0;
      mem_ptr <= '0;
      pending <= '0;
    end else begin
      pending <= alu_grt | mem_grt;
      if (|alu_grt) alu_ptr <= alu_pick[PTR_W-1:0] + PTR_W'(1);
      if (|mem_grt) mem_ptr <= mem_pick[PTR_W-1:0] + PTR_W'(1);
    end
  end

  assign bus.ALU_Grt    = alu_grt;
  assign bus.MEM_Grt    = mem_grt;
  assign bus.Release_OC = pending;
  assign bus.Pending_OC = pending;

endmodule

// File: tb/tb_oc_dispatch_arbiter.sv
// Directed bench for oc_dispatch_arbiter: vector table plus hand-written reset sequences.
module tb_oc_dispatch_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  oc_dispatch_arbiter_if #(.NUM_OC(4)) bus ();

  oc_dispatch_arbiter #(.NUM_OC(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0] ready;
    logic [3:0] is_mem;
    logic       alu_rdy;
    logic       mem_rdy;
    logic [3:0] exp_alu;
    logic [3:0] exp_mem;
    logic [3:0] exp_rel;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] ready, input logic [3:0] is_mem,
                       input logic ar, input logic mr);
    bus.Ready_OC  = ready;
    bus.Is_Mem_OC = is_mem;
    bus.ALU_Ready = ar;
    bus.MEM_Ready = mr;
  endtask

  initial begin
    //                 ready    is_mem  ar    mr    alu      mem      rel
    vecs[0]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0001};
    vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0010};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b0100};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b1000};
    vecs[5]  = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0001};
    vecs[6]  = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0010};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001};
    vecs[8]  = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0011};
    vecs[10] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[12] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[13] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'b1000, 4'b0000};
    vecs[14] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1000};
    vecs[15] = '{4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    vecs[16] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001};
    vecs[17] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[18] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000};
    vecs[19] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100};
    vecs[20] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000};
    vecs[21] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100};
    vecs[22] = '{4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[23] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[24] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b0000};
    vecs[25] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1000};

    // Reset held with everything requesting: no grants, no release.
    drive(4'hF, 4'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_grt", bus.ALU_Grt, 4'b0000);
    chk("rst_mem_grt", bus.MEM_Grt, 4'b0000);
    chk("rst_release", bus.Release_OC, 4'b0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ready, vecs[i].is_mem, vecs[i].alu_rdy, vecs[i].mem_rdy);
      #1;
      chk($sformatf("v%0d_alu_grt", i), bus.ALU_Grt, vecs[i].exp_alu);
      chk($sformatf("v%0d_mem_grt", i), bus.MEM_Grt, vecs[i].exp_mem);
      chk($sformatf("v%0d_release", i), bus.Release_OC, vecs[i].exp_rel);
      chk($sformatf("v%0d_pending", i), bus.Pending_OC, vecs[i].exp_rel);
      @(posedge clk);
      #1;
    end

    // Async reset between edges while Pending=0010; ALU pointer is 0 here.
    drive(4'b0010, 4'b0000, 1'b1, 1'b1);
    #1;
    chk("pre_rst_alu_grt", bus.ALU_Grt, 4'b0010);
    @(posedge clk);
    #1;
    chk("pre_rst_release", bus.Release_OC, 4'b0010);
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_release", bus.Release_OC, 4'b0000);
    chk("async_rst_pending", bus.Pending_OC, 4'b0000);
    drive(4'b1111, 4'b0000, 1'b1, 1'b1);
    #1;
    chk("async_rst_alu_grt", bus.ALU_Grt, 4'b0000);
    @(posedge clk);
    #1;
    chk("held_rst_release", bus.Release_OC, 4'b0000);

    // Both pointers back at 0 after reset release.
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ptr0", bus.ALU_Grt, 4'b0001);
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    #1;
    chk("post_rst_mem_ptr0", bus.MEM_Grt, 4'b0001);
    chk("post_rst_alu_none", bus.ALU_Grt, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_rst_release", bus.Release_OC, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
